alu_mc: RTL and testbench
=========================

# alu_mc

Parametrised, registered ALU with iterative multiply/divide: the next-generation datapath ALU for the MIPS core. It adds variable shift amounts, set-less-than, signed-overflow detection and WIDTH-cycle multiply/divide behind a valid/ready handshake. It sits in the EX stage; the pipeline stalls on `ready` while a multi-cycle operation is in flight.

## Interface
- `WIDTH`, 32, operand/result width; ≥ 4, power of two.
- `clk`  in  1  rising-edge clock.
- `reset`  in  1  synchronous, active-high.
- `valid_in`  in  1  operands and op present this cycle.
- `ready`  out  1  block can accept; a transfer occurs on the edge where `valid_in && ready`.
- `in_1`, `in_2`  in  WIDTH each  operands.
- `alu_op`  in  4  ADD=0, SUB=1, AND=2, OR=3, NOR=4, XOR=5, SLL=6, SRL=7, SRA=8, SLT=9, SLTU=10, MUL=11, MULU=12, DIV=13, DIVU=14; 15 is reserved.
- `out`  out  WIDTH  result (low product / quotient for MUL*/DIV*).
- `out_hi`  out  WIDTH  high product for MUL*, remainder for DIV*, 0 otherwise.
- `zero`  out  1  `out == 0`.
- `overflow`  out  1  signed overflow (ADD/SUB) or signed DIV of MIN by -1.
- `div_zero`  out  1  DIV/DIVU with `in_2 == 0`.
- `valid_out`  out  1  one-cycle pulse: result outputs updated this cycle.

## Operation
- FSM states: IDLE, BUSY.
- IDLE: `ready` = 1.
  - Accept of ops 0–10 computes combinationally and registers all outputs at the accept edge. `valid_out` = 1 the next cycle. State stays IDLE.
  - Accept of ops 11–14 latches the operands and enters BUSY with the iteration counter set to WIDTH.
- Shifts:
  - Shift amount is `in_2[log2(WIDTH)-1:0]`; the shifted operand is `in_1`.
  - SRA replicates `in_1[WIDTH-1]`.
- SLT is signed and SLTU is unsigned. Both set `out` to 1 or 0.
- ADD/SUB wrap modulo 2^WIDTH. `overflow` is set when the operands have the same sign (ADD) or different signs (SUB) and the result sign differs from `in_1`'s sign.
- MUL/MULU:
  - Radix-2 shift-add, one bit per cycle, producing the 2·WIDTH-bit product as {`out_hi`,`out`}.
  - MUL is signed; it uses magnitudes and negates the result if the operand signs differ.
- DIV/DIVU:
  - Restoring division, one quotient bit per cycle.
  - Signed DIV truncates toward zero. The remainder takes the sign of the dividend.
  - `in_2 == 0`: `out` = all ones, `out_hi` = `in_1`, `div_zero` = 1. This takes the full latency; there is no early exit.
  - DIV of MIN by -1: `out` = MIN, `out_hi` = 0, `overflow` = 1.
- BUSY:
  - `ready` = 0. `valid_in` is ignored.
  - The counter decrements each cycle. At 0, outputs are registered, `valid_out` pulses and the FSM returns to IDLE.
- Op 15: accepted, `out` = 0, `out_hi` = 0, all flags 0, `valid_out` pulses.
- Flags not applicable to an op are 0.
- All result outputs hold their value between `valid_out` pulses.

## Timing
- Reset:
  - FSM = IDLE and counter = 0.
  - `ready` = 1; `out` = 0, `out_hi` = 0, `valid_out` = 0, `overflow` = 0, `div_zero` = 0.
  - `zero` = 1, since `out` = 0.
- Reset mid-BUSY aborts the operation. No `valid_out` is produced, and the above values appear the cycle after the reset edge.
- Single-cycle ops:
  - Latency 1: accept at edge E, results and `valid_out` are visible after E.
  - Back-to-back accepts every cycle are allowed.
- Multi-cycle ops:
  - Accept at edge E. `ready` = 0 from E+1 up to and including E+WIDTH.
  - Results and `valid_out` appear after edge E+WIDTH. `ready` returns to 1 in that same cycle.
  - A new op may therefore be accepted at edge E+WIDTH+1. Throughput is one op per WIDTH+1 cycles.
- `zero` is derived from the registered `out`, so it is valid whenever `out` is.

## Test plan
- Reset, then check `ready`=1, `out`=0, `zero`=1 and `valid_out`=0. Then assert `reset` during a DIV mid-BUSY: expect no `valid_out`, and `ready`=1 the next cycle.
- ADD 0x7FFFFFFF+1 → `out`=0x80000000, `overflow`=1. Back-to-back SUB 5−5 → `out`=0, `zero`=1. SLT -1<1 → 1 and SLTU -1<1 → 0. Expect one `valid_out` per cycle.
- Shifts with WIDTH=32, in_1=0x80000010, in_2=0x24 (shift 4): SLL → 0x00000100, SRL → 0x08000001, SRA → 0xF8000001.
- MUL -3×7 → {`out_hi`,`out`}={0xFFFFFFFF,0xFFFFFFEB}. MULU 0xFFFFFFFF×2 → {1,0xFFFFFFFE}. `valid_out` must arrive exactly 32 cycles after the accept, and `valid_in` during BUSY must be ignored.
- DIV -7/2 → `out`=-3, `out_hi`=-1. DIVU 7/0 → `out`=0xFFFFFFFF, `out_hi`=7, `div_zero`=1. DIV 0x80000000/-1 → `out`=0x80000000, `overflow`=1.
- Rerun the ADD, shift and MUL cases with WIDTH=8: MUL -3×7 → {0xFF,0xEB}, with latency 8.

Source files
------------

// File: rtl/alu_mc.sv
// Registered EX-stage ALU: single-cycle logic/arith/shift ops plus iterative
// radix-2 multiply and restoring divide behind a valid/ready handshake.
module alu_mc #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             valid_in,
  output logic             ready,
  input  logic [WIDTH-1:0] in_1,
  input  logic [WIDTH-1:0] in_2,
  input  logic [3:0]       alu_op,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic             zero,
  output logic             overflow,
  output logic             div_zero,
  output logic             valid_out
);

  localparam int SH_W  = $clog2(WIDTH);
  localparam int CNT_W = SH_W + 1;
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  localparam logic [3:0] OP_ADD  = 4'd0;
  localparam logic [3:0] OP_SUB  = 4'd1;
  localparam logic [3:0] OP_AND  = 4'd2;
  localparam logic [3:0] OP_OR   = 4'd3;
  localparam logic [3:0] OP_NOR  = 4'd4;
  localparam logic [3:0] OP_XOR  = 4'd5;
  localparam logic [3:0] OP_SLL  = 4'd6;
  localparam logic [3:0] OP_SRL  = 4'd7;
  localparam logic [3:0] OP_SRA  = 4'd8;
  localparam logic [3:0] OP_SLT  = 4'd9;
  localparam logic [3:0] OP_SLTU = 4'd10;
  localparam logic [3:0] OP_MUL  = 4'd11;
  localparam logic [3:0] OP_MULU = 4'd12;
  localparam logic [3:0] OP_DIV  = 4'd13;
  localparam logic [3:0] OP_DIVU = 4'd14;

  typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

  function automatic logic [WIDTH-1:0] cond_neg(input logic [WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  function automatic logic [2*WIDTH-1:0] cond_neg2(input logic [2*WIDTH-1:0] x, input logic n);
    return n ? -x : x;
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [WIDTH-1:0]   out_q, out_d, out_hi_q, out_hi_d;
  logic               ovf_q, ovf_d, dz_q, dz_d, vout_q, vout_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   acc_hi_q, acc_hi_d, acc_lo_q, acc_lo_d;
  logic [WIDTH-1:0]   opb_q, opb_d, dvd_q, dvd_d;
  logic               neg_q_q, neg_q_d, neg_r_q, neg_r_d;
  logic               dz_pend_q, dz_pend_d, ovf_pend_q, ovf_pend_d;

  logic signed [WIDTH-1:0] in_1_s, in_2_s;
  logic [SH_W-1:0]    shamt;
  logic [WIDTH-1:0]   sum, diff, sc_out;
  logic               sc_ovf;
  logic               is_multi, is_signed_op, is_mul_q;
  logic [WIDTH:0]     mul_sum, div_sh;
  logic               div_ge;
  logic [WIDTH-1:0]   div_rem, it_hi, it_lo, fin_out, fin_hi;
  logic               fin_ovf, fin_dz;
  logic [2*WIDTH-1:0] prod_full;

  assign in_1_s       = $signed(in_1);
  assign in_2_s       = $signed(in_2);
  assign shamt        = in_2[SH_W-1:0];
  assign sum          = in_1 + in_2;
  assign diff         = in_1 - in_2;
  assign is_multi     = (alu_op == OP_MUL) || (alu_op == OP_MULU) ||
                        (alu_op == OP_DIV) || (alu_op == OP_DIVU);
  assign is_signed_op = (alu_op == OP_MUL) || (alu_op == OP_DIV);
  assign is_mul_q     = (op_q == OP_MUL) || (op_q == OP_MULU);

  always_comb begin : single_cycle
    sc_out = '0;
    sc_ovf = 1'b0;
    case (alu_op)
      OP_ADD: begin
        sc_out = sum;
        sc_ovf = (in_1[WIDTH-1] == in_2[WIDTH-1]) && (sum[WIDTH-1] != in_1[WIDTH-1]);
      end
      OP_SUB: begin
        sc_out = diff;
        sc_ovf = (in_1[WIDTH-1] != in_2[WIDTH-1]) && (diff[WIDTH-1] != in_1[WIDTH-1]);
      end
      OP_AND:  sc_out = in_1 & in_2;
      OP_OR:   sc_out = in_1 | in_2;
      OP_NOR:  sc_out = ~(in_1 | in_2);
      OP_XOR:  sc_out = in_1 ^ in_2;
      OP_SLL:  sc_out = in_1 << shamt;
      OP_SRL:  sc_out = in_1 >> shamt;
      OP_SRA:  sc_out = in_1_s >>> shamt;
      OP_SLT:  sc_out = {{(WIDTH-1){1'b0}}, in_1_s < in_2_s};
      OP_SLTU: sc_out = {{(WIDTH-1){1'b0}}, in_1 < in_2};
      default: ;
    endcase
  end

  // One multiply/divide step per cycle; acc_hi is partial product / remainder
  always_comb begin : iterate
    mul_sum = {1'b0, acc_hi_q} + (acc_lo_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});
    div_sh  = {acc_hi_q, acc_lo_q[WIDTH-1]};
    div_ge  = div_sh >= {1'b0, opb_q};
    div_rem = div_sh[WIDTH-1:0] - opb_q;
    if (is_mul_q) begin
      it_hi = mul_sum[WIDTH:1];
      it_lo = {mul_sum[0], acc_lo_q[WIDTH-1:1]};
    end else begin
      it_hi = div_ge ? div_rem : div_sh[WIDTH-1:0];
      it_lo = {acc_lo_q[WIDTH-2:0], div_ge};
    end
  end

  always_comb begin : finish
    prod_full = cond_neg2({it_hi, it_lo}, neg_q_q);
    fin_ovf   = 1'b0;
    fin_dz    = 1'b0;
    if (is_mul_q) begin
      fin_out = prod_full[WIDTH-1:0];
      fin_hi  = prod_full[2*WIDTH-1:WIDTH];
    end else if (dz_pend_q) begin
      fin_out = '1;
      fin_hi  = dvd_q;
      fin_dz  = 1'b1;
    end else if (ovf_pend_q) begin
      fin_out = MIN_VAL;
      fin_hi  = '0;
      fin_ovf = 1'b1;
    end else begin
      fin_out = cond_neg(it_lo, neg_q_q);
      fin_hi  = cond_neg(it_hi, neg_r_q);
    end
  end

  always_comb begin : next_state
    state_d    = state_q;
    cnt_d      = cnt_q;
    out_d      = out_q;
    out_hi_d   = out_hi_q;
    ovf_d      = ovf_q;
    dz_d       = dz_q;
    vout_d     = 1'b0;
    op_d       = op_q;
    acc_hi_d   = acc_hi_q;
    acc_lo_d   = acc_lo_q;
    opb_d      = opb_q;
    dvd_d      = dvd_q;
    neg_q_d    = neg_q_q;
    neg_r_d    = neg_r_q;
    dz_pend_d  = dz_pend_q;
    ovf_pend_d = ovf_pend_q;
    case (state_q)
      IDLE: begin
        if (valid_in) begin
          if (is_multi) begin
            state_d    = BUSY;
            cnt_d      = CNT_W'(WIDTH);
            op_d       = alu_op;
            acc_hi_d   = '0;
            acc_lo_d   = cond_neg(in_1, is_signed_op && in_1[WIDTH-1]);
            opb_d      = cond_neg(in_2, is_signed_op && in_2[WIDTH-1]);
            neg_q_d    = is_signed_op && (in_1[WIDTH-1] ^ in_2[WIDTH-1]);
            neg_r_d    = is_signed_op && in_1[WIDTH-1];
            dvd_d      = in_1;
            dz_pend_d  = ((alu_op == OP_DIV) || (alu_op == OP_DIVU)) && (in_2 == '0);
            ovf_pend_d = (alu_op == OP_DIV) && (in_1 == MIN_VAL) && (in_2 == '1);
          end else begin
            out_d    = sc_out;
            out_hi_d = '0;
            ovf_d    = sc_ovf;
            dz_d     = 1'b0;
            vout_d   = 1'b1;
          end
        end
      end
      BUSY: begin
        acc_hi_d = it_hi;
        acc_lo_d = it_lo;
        cnt_d    = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d  = IDLE;
          out_d    = fin_out;
          out_hi_d = fin_hi;
          ovf_d    = fin_ovf;
          dz_d     = fin_dz;
          vout_d   = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      out_q    <= '0;
      out_hi_q <= '0;
      ovf_q    <= 1'b0;
      dz_q     <= 1'b0;
      vout_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      out_q    <= out_d;
      out_hi_q <= out_hi_d;
      ovf_q    <= ovf_d;
      dz_q     <= dz_d;
      vout_q   <= vout_d;
    end
  end

  // Operand/iteration datapath carries no reset; it is always reloaded on accept
  always_ff @(posedge clk) begin
    op_q       <= op_d;
    acc_hi_q   <= acc_hi_d;
    acc_lo_q   <= acc_lo_d;
    opb_q      <= opb_d;
    dvd_q      <= dvd_d;
    neg_q_q    <= neg_q_d;
    neg_r_q    <= neg_r_d;
    dz_pend_q  <= dz_pend_d;
    ovf_pend_q <= ovf_pend_d;
  end

  always_comb begin : outputs
    ready     = (state_q == IDLE);
    zero      = (out_q == '0);
    out       = out_q;
    out_hi    = out_hi_q;
    overflow  = ovf_q;
    div_zero  = dz_q;
    valid_out = vout_q;
  end

endmodule

// File: tb/tb_alu_mc.sv
// Scoreboard bench for alu_mc at WIDTH=32 and WIDTH=8: expected results are
// queued at issue and compared, with latency, when valid_out pulses.
module tb_alu_mc;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic        v32, r32, z32, ov32, dz32, vo32;
  logic [3:0]  op32;
  logic [31:0] a32, b32, o32, h32;
  logic        v8, r8, z8, ov8, dz8, vo8;
  logic [3:0]  op8;
  logic [7:0]  a8, b8, o8, h8;

  alu_mc #(.WIDTH(32)) dut32 (
    .clk(clk), .reset(reset), .valid_in(v32), .ready(r32), .in_1(a32), .in_2(b32),
    .alu_op(op32), .out(o32), .out_hi(h32), .zero(z32), .overflow(ov32),
    .div_zero(dz32), .valid_out(vo32)
  );

  alu_mc #(.WIDTH(8)) dut8 (
    .clk(clk), .reset(reset), .valid_in(v8), .ready(r8), .in_1(a8), .in_2(b8),
    .alu_op(op8), .out(o8), .out_hi(h8), .zero(z8), .overflow(ov8),
    .div_zero(dz8), .valid_out(vo8)
  );

  typedef struct {
    logic [31:0] o;
    logic [31:0] h;
    logic        ov;
    logic        dz;
    int          lat;
    int          acc;
    string       tag;
  } exp_t;

  exp_t q32[$];
  exp_t q8[$];
  exp_t e32, e8;
  int n_chk = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    if (vo32) begin
      if (q32.size() == 0) chk("w32.spurious_valid_out", {31'b0, vo32}, 32'd0);
      else begin
        e32 = q32.pop_front();
        chk({e32.tag, ".out"}, o32, e32.o);
        chk({e32.tag, ".out_hi"}, h32, e32.h);
        chk({e32.tag, ".zero"}, {31'b0, z32}, {31'b0, e32.o == 32'd0});
        chk({e32.tag, ".overflow"}, {31'b0, ov32}, {31'b0, e32.ov});
        chk({e32.tag, ".div_zero"}, {31'b0, dz32}, {31'b0, e32.dz});
        chk({e32.tag, ".latency"}, 32'(cyc - e32.acc), 32'(e32.lat));
      end
    end
  end

  always @(negedge clk) begin
    if (vo8) begin
      if (q8.size() == 0) chk("w8.spurious_valid_out", {31'b0, vo8}, 32'd0);
      else begin
        e8 = q8.pop_front();
        chk({e8.tag, ".out"}, {24'b0, o8}, e8.o);
        chk({e8.tag, ".out_hi"}, {24'b0, h8}, e8.h);
        chk({e8.tag, ".zero"}, {31'b0, z8}, {31'b0, e8.o == 32'd0});
        chk({e8.tag, ".overflow"}, {31'b0, ov8}, {31'b0, e8.ov});
        chk({e8.tag, ".div_zero"}, {31'b0, dz8}, {31'b0, e8.dz});
        chk({e8.tag, ".latency"}, 32'(cyc - e8.acc), 32'(e8.lat));
      end
    end
  end

  // Holds valid_in (and the op) until ready, so ops issued while BUSY are offered but must be ignored
  task automatic issue(input bit d8, input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] eo, input logic [31:0] eh, input logic eov, input logic edz,
                       input string tag);
    exp_t e;
    int n;
    @(negedge clk);
    if (d8) begin v8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0]; end
    else begin v32 = 1'b1; op32 = op; a32 = a; b32 = b; end
    n = 0;
    while (!(d8 ? r8 : r32) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!(d8 ? r8 : r32)) chk({tag, ".ready_timeout"}, {31'b0, (d8 ? r8 : r32)}, 32'd1);
    else begin
      e.o = eo; e.h = eh; e.ov = eov; e.dz = edz; e.tag = tag;
      e.lat = (op >= 4'd11 && op <= 4'd14) ? (d8 ? 8 : 32) : 0;
      e.acc = cyc + 1;
      if (d8) q8.push_back(e);
      else q32.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    v32 = 1'b0;
    v8  = 1'b0;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((q32.size() != 0 || q8.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    chk("drain.pending", 32'(q32.size() + q8.size()), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected $finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    v32 = 1'b0; op32 = 4'd0; a32 = '0; b32 = '0;
    v8  = 1'b0; op8  = 4'd0; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    chk("rst.ready32", {31'b0, r32}, 32'd1);
    chk("rst.out32", o32, 32'd0);
    chk("rst.out_hi32", h32, 32'd0);
    chk("rst.zero32", {31'b0, z32}, 32'd1);
    chk("rst.valid_out32", {31'b0, vo32}, 32'd0);
    chk("rst.flags32", {30'b0, ov32, dz32}, 32'd0);
    chk("rst.ready8", {31'b0, r8}, 32'd1);
    chk("rst.zero8", {31'b0, z8}, 32'd1);

    // Reset in the middle of a DIV: no result may ever appear
    issue(0, 4'd13, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0, 1'b0, "div_abort");
    idle();
    repeat (5) @(negedge clk);
    chk("abort.busy_ready", {31'b0, r32}, 32'd0);
    q32.delete();
    reset = 1'b1;
    @(negedge clk);
    chk("abort.ready", {31'b0, r32}, 32'd1);
    chk("abort.valid_out", {31'b0, vo32}, 32'd0);
    chk("abort.out", o32, 32'd0);
    chk("abort.zero", {31'b0, z32}, 32'd1);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    chk("abort.ready_after", {31'b0, r32}, 32'd1);

    // Back-to-back single-cycle ops, WIDTH=32
    issue(0, 4'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000, 32'h0, 1'b1, 1'b0, "add_ovf");
    issue(0, 4'd1,  32'd5,        32'd5,        32'h00000000, 32'h0, 1'b0, 1'b0, "sub_zero");
    issue(0, 4'd9,  32'hFFFFFFFF, 32'h00000001, 32'h00000001, 32'h0, 1'b0, 1'b0, "slt");
    issue(0, 4'd10, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 32'h0, 1'b0, 1'b0, "sltu");
    issue(0, 4'd2,  32'hF0F01234, 32'h0FF0FFFF, 32'h00F01234, 32'h0, 1'b0, 1'b0, "and");
    issue(0, 4'd3,  32'hF0000000, 32'h0000000F, 32'hF000000F, 32'h0, 1'b0, 1'b0, "or");
    issue(0, 4'd4,  32'h00000000, 32'h00000000, 32'hFFFFFFFF, 32'h0, 1'b0, 1'b0, "nor");
    issue(0, 4'd5,  32'hAAAA5555, 32'hFFFF0000, 32'h55555555, 32'h0, 1'b0, 1'b0, "xor");
    issue(0, 4'd1,  32'h80000000, 32'h00000001, 32'h7FFFFFFF, 32'h0, 1'b1, 1'b0, "sub_ovf");
    issue(0, 4'd6,  32'h80000010, 32'h00000024, 32'h00000100, 32'h0, 1'b0, 1'b0, "sll");
    issue(0, 4'd7,  32'h80000010, 32'h00000024, 32'h08000001, 32'h0, 1'b0, 1'b0, "srl");
    issue(0, 4'd8,  32'h80000010, 32'h00000024, 32'hF8000001, 32'h0, 1'b0, 1'b0, "sra");
    issue(0, 4'd15, 32'h12345678, 32'h9ABCDEF0, 32'h00000000, 32'h0, 1'b0, 1'b0, "op15");

    // Multi-cycle ops; each following issue offers valid_in while BUSY
    issue(0, 4'd11, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFEB, 32'hFFFFFFFF, 1'b0, 1'b0, "mul");
    issue(0, 4'd0,  32'd1,        32'd2,        32'd3,        32'h0,        1'b0, 1'b0, "add_after_mul");
    issue(0, 4'd12, 32'hFFFFFFFF, 32'd2,        32'hFFFFFFFE, 32'h00000001, 1'b0, 1'b0, "mulu");
    issue(0, 4'd13, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0, 1'b0, "div_neg");
    issue(0, 4'd14, 32'd7,        32'd0,        32'hFFFFFFFF, 32'd7,        1'b0, 1'b1, "divu_zero");
    issue(0, 4'd13, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'h0,        1'b1, 1'b0, "div_min");
    issue(0, 4'd13, 32'd100,      32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2,        1'b0, 1'b0, "div_sdiv");
    idle();
    drain();

    // WIDTH=8 instance
    issue(1, 4'd0,  32'h7F, 32'h01, 32'h80, 32'h00, 1'b1, 1'b0, "w8_add_ovf");
    issue(1, 4'd6,  32'h81, 32'h0B, 32'h08, 32'h00, 1'b0, 1'b0, "w8_sll");
    issue(1, 4'd7,  32'h81, 32'h0B, 32'h10, 32'h00, 1'b0, 1'b0, "w8_srl");
    issue(1, 4'd8,  32'h81, 32'h0B, 32'hF0, 32'h00, 1'b0, 1'b0, "w8_sra");
    issue(1, 4'd11, 32'hFD, 32'h07, 32'hEB, 32'hFF, 1'b0, 1'b0, "w8_mul");
    issue(1, 4'd1,  32'h10, 32'h01, 32'h0F, 32'h00, 1'b0, 1'b0, "w8_sub_after_mul");
    idle();
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
